// File: rtl/bip_program_loader.sv
// bip_program_loader
// Writer side of the BIP program memory. Assembles 16-bit instruction words
// {opcode, operand} from a byte stream (high byte first) and writes them
// sequentially into program memory starting at address 0. Any word whose
// opcode lies above MAX_OPCODE is written as HALT (all zeros) and counted,
// so the instruction decoder never fetches an undefined opcode.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start, len       start pulse and word count (0 means 2^ADDR_W words)
//   abort            cancels a load in progress, no further writes
//   byte_valid/data  incoming byte stream
//   byte_ready       byte accepted when byte_valid & byte_ready
//   pm_we/addr/wdata program memory write port
//   busy, done       load in progress / one-cycle completion pulse
//   err_opcode       sticky illegal-opcode flag, cleared by start
//   err_count        number of illegal words in the current/last load
module bip_program_loader #(
    parameter int ADDR_W     = 11,
    parameter int INSTR_W    = 16,
    parameter int OPCODE_W   = 5,
    parameter int MAX_OPCODE = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   len,
    input  logic                abort,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic                pm_we,
    output logic [ADDR_W-1:0]   pm_addr,
    output logic [INSTR_W-1:0]  pm_wdata,
    output logic                busy,
    output logic                done,
    output logic                err_opcode,
    output logic [ADDR_W:0]     err_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_HI,
        ST_GET_LO,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [OPCODE_W-1:0] MAX_OP   = OPCODE_W'(MAX_OPCODE);
    localparam logic [ADDR_W:0]     REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]     FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t                 state_q, state_d;
    logic [ADDR_W:0]        remaining_q, remaining_d;
    logic [INSTR_W-9:0]     hi_q, hi_d;
    logic                   pm_we_q, pm_we_d;
    logic [ADDR_W-1:0]      pm_addr_q, pm_addr_d;
    logic [INSTR_W-1:0]     pm_wdata_q, pm_wdata_d;
    logic                   err_opcode_q, err_opcode_d;
    logic [ADDR_W:0]        err_count_q, err_count_d;

    logic                   xfer;
    logic [INSTR_W-1:0]     word;
    logic                   illegal;

    // Abort wins over byte transfer, so the handshake is withdrawn in the
    // abort cycle rather than letting the source believe a byte was taken.
    assign byte_ready = ((state_q == ST_GET_HI) || (state_q == ST_GET_LO)) && !abort;
    assign xfer       = byte_valid && byte_ready;
    assign word       = {hi_q, byte_data};
    assign illegal    = word[INSTR_W-1 -: OPCODE_W] > MAX_OP;

    // Next-state and datapath updates. The write strobe is prepared on the
    // low-byte transfer so it is registered and lines up with the WRITE state.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        hi_d         = hi_q;
        pm_we_d      = 1'b0;
        pm_addr_d    = pm_addr_q;
        pm_wdata_d   = pm_wdata_q;
        err_opcode_d = err_opcode_q;
        err_count_d  = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    remaining_d  = (len == '0) ? FULL_LEN : {1'b0, len};
                    pm_addr_d    = '0;
                    err_opcode_d = 1'b0;
                    err_count_d  = '0;
                    state_d      = ST_GET_HI;
                end
            end
            ST_GET_HI: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    hi_d    = byte_data;
                    state_d = ST_GET_LO;
                end
            end
            ST_GET_LO: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    pm_we_d = 1'b1;
                    state_d = ST_WRITE;
                    if (illegal) begin
                        pm_wdata_d   = '0;
                        err_opcode_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + REM_ONE;
                        end
                    end else begin
                        pm_wdata_d = word;
                    end
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    remaining_d = remaining_q - REM_ONE;
                    // The address stays on the last word so a full load
                    // finishes at 2^ADDR_W-1 instead of wrapping to 0.
                    if (remaining_q == REM_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        pm_addr_d = pm_addr_q + ADDR_W'(1);
                        state_d   = ST_GET_HI;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            hi_q         <= '0;
            pm_we_q      <= 1'b0;
            pm_addr_q    <= '0;
            pm_wdata_q   <= '0;
            err_opcode_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            hi_q         <= hi_d;
            pm_we_q      <= pm_we_d;
            pm_addr_q    <= pm_addr_d;
            pm_wdata_q   <= pm_wdata_d;
            err_opcode_q <= err_opcode_d;
            err_count_q  <= err_count_d;
        end
    end

    // An abort arriving during WRITE or DONE must still cancel the strobe
    // or pulse of that same cycle, hence the gating on the registered values.
    assign pm_we      = pm_we_q && !abort;
    assign done       = (state_q == ST_DONE) && !abort;
    assign busy       = (state_q != ST_IDLE);
    assign pm_addr    = pm_addr_q;
    assign pm_wdata   = pm_wdata_q;
    assign err_opcode = err_opcode_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// tb_bip_program_loader
// Drives directed and randomized loads into bip_program_loader (ADDR_W=3 so
// a full 2^ADDR_W load is short) and compares the observed write stream,
// error flags and done pulses against a word-level reference model.
module tb_bip_program_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   len = '0;
    logic                abort = 1'b0;
    logic                byte_valid = 1'b0;
    logic [7:0]          byte_data = 8'h00;
    logic                byte_ready;
    logic                pm_we;
    logic [ADDR_W-1:0]   pm_addr;
    logic [15:0]         pm_wdata;
    logic                busy;
    logic                done;
    logic                err_opcode;
    logic [ADDR_W:0]     err_count;

    bip_program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .pm_we      (pm_we),
        .pm_addr    (pm_addr),
        .pm_wdata   (pm_wdata),
        .busy       (busy),
        .done       (done),
        .err_opcode (err_opcode),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int doneCount = 0;
    int readyInWrite = 0;
    int lastWeCycle = 0;
    int lastDoneCycle = 0;
    logic [ADDR_W+15:0] writeQ[$];
    logic [7:0] stimBytes[$];

    always @(posedge clk) cycle++;

    // Passive monitor: records every write and done pulse in mid-cycle.
    always @(negedge clk) begin
        if (pm_we) begin
            writeQ.push_back({pm_addr, pm_wdata});
            lastWeCycle = cycle;
            if (byte_ready) readyInWrite++;
        end
        if (done) begin
            doneCount++;
            lastDoneCycle = cycle;
        end
    end

    // Reference rule: the opcode is the top five bits of the 16-bit word;
    // anything above 7 is replaced by HALT (zero).
    function automatic logic [15:0] modelWord(input logic [7:0] h, input logic [7:0] l);
        int w;
        w = int'(h) * 256 + int'(l);
        if ((w / 2048) > 7) return 16'h0000;
        return 16'(w);
    endfunction

    function automatic int modelIllegal(input logic [7:0] h);
        return ((int'(h) / 8) > 7) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input int maxGap);
        int gap;
        int guard;
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        repeat (gap) step();
        byte_valid = 1'b1;
        byte_data  = b;
        guard = 0;
        @(negedge clk);
        while (!byte_ready && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        checkOutput("byte_ready_seen", {31'b0, byte_ready}, 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic startLoad(input int lenIn);
        writeQ.delete();
        readyInWrite = 0;
        start = 1'b1;
        len   = ADDR_W'(lenIn);
        step();
        start = 1'b0;
        checkOutput("start_busy", {31'b0, busy}, 32'd1);
        checkOutput("start_err_clr", {31'b0, err_opcode}, 32'd0);
        checkOutput("start_cnt_clr", {28'b0, err_count}, 32'd0);
        checkOutput("start_addr0", {29'b0, pm_addr}, 32'd0);
    endtask

    task automatic applyStimulus(input int lenIn, input int nWords, input int maxGap);
        startLoad(lenIn);
        for (int i = 0; i < 2 * nWords; i++) begin
            sendByte(stimBytes[i], maxGap);
        end
    endtask

    task automatic checkLoad(input string tag, input int nWords, input int doneBefore);
        int guard;
        int errs;
        guard = 0;
        while (doneCount == doneBefore && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_done_pulses"}, doneCount - doneBefore, 32'd1);
        step();
        checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_done_low"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_nwrites"}, writeQ.size(), nWords);
        errs = 0;
        for (int i = 0; i < nWords; i++) begin
            errs += modelIllegal(stimBytes[2*i]);
            if (i < writeQ.size()) begin
                checkOutput({tag, "_write"}, 32'(writeQ[i]),
                            32'({ADDR_W'(i), modelWord(stimBytes[2*i], stimBytes[2*i+1])}));
            end
        end
        checkOutput({tag, "_err_count"}, {28'b0, err_count}, errs);
        checkOutput({tag, "_err_opcode"}, {31'b0, err_opcode}, (errs > 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_ready_in_write"}, readyInWrite, 32'd0);
    endtask

    task automatic fillRandom(input int nBytes);
        stimBytes.delete();
        for (int i = 0; i < nBytes; i++) stimBytes.push_back(8'($urandom));
    endtask

    initial begin
        int db;
        int n;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_ready", {31'b0, byte_ready}, 32'd0);
        checkOutput("rst_we", {31'b0, pm_we}, 32'd0);
        checkOutput("rst_addr", {29'b0, pm_addr}, 32'd0);
        checkOutput("rst_wdata", {16'b0, pm_wdata}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {28'b0, err_count, err_opcode}, 32'd0);

        // Two legal words, done one cycle after the last write.
        stimBytes = '{8'h18, 8'h05, 8'h20, 8'h0A};
        db = doneCount;
        applyStimulus(2, 2, 0);
        checkLoad("t2", 2, db);
        checkOutput("t2_done_latency", lastDoneCycle - lastWeCycle, 32'd1);

        // Opcode 31 becomes HALT and is flagged.
        stimBytes = '{8'hF8, 8'h01};
        db = doneCount;
        applyStimulus(1, 1, 0);
        checkLoad("t3", 1, db);

        // Gappy stream of four words; the start also proves the flags clear.
        fillRandom(8);
        db = doneCount;
        applyStimulus(4, 4, 3);
        checkLoad("t4", 4, db);

        // Assorted random loads, including full-depth ones via len=0.
        repeat (6) begin
            n = int'($urandom_range(DEPTH, 1));
            fillRandom(2 * n);
            db = doneCount;
            applyStimulus((n == DEPTH) ? 0 : n, n, int'($urandom_range(2, 0)));
            checkLoad("rnd", n, db);
        end

        // Reset while waiting for the low byte.
        fillRandom(4);
        startLoad(2);
        sendByte(8'h18, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", {31'b0, byte_ready}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_out", {pm_we, done, err_opcode, err_count, pm_addr, pm_wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("midrst_idle", {31'b0, busy}, 32'd0);

        // Start while busy is ignored; abort in the WRITE of word 2 drops it.
        fillRandom(6);
        db = doneCount;
        startLoad(3);
        sendByte(stimBytes[0], 0);
        sendByte(stimBytes[1], 0);
        start = 1'b1;
        len   = ADDR_W'(5);
        sendByte(stimBytes[2], 0);
        start = 1'b0;
        sendByte(stimBytes[3], 0);
        abort = 1'b1;
        @(negedge clk);
        checkOutput("abort_we", {31'b0, pm_we}, 32'd0);
        checkOutput("abort_ready", {31'b0, byte_ready}, 32'd0);
        checkOutput("abort_addr", {29'b0, pm_addr}, 32'd1);
        step();
        abort = 1'b0;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        repeat (4) step();
        checkOutput("abort_no_done", doneCount - db, 32'd0);
        checkOutput("abort_nwrites", writeQ.size(), 32'd1);
        if (writeQ.size() > 0) begin
            checkOutput("abort_word0", 32'(writeQ[0]),
                        32'({ADDR_W'(0), modelWord(stimBytes[0], stimBytes[1])}));
        end

        // Full-depth load, last write at the top address with no wrap.
        fillRandom(2 * DEPTH);
        db = doneCount;
        applyStimulus(0, DEPTH, 1);
        checkLoad("full", DEPTH, db);
        checkOutput("full_last_addr", {29'b0, pm_addr}, DEPTH - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
